pcm_sample_fetch: RTL and testbench

Downstream consumer of the current-address generator in the music player datapath. Once per sample period it reads one 8-bit PCM sample from song memory at the generator's 22-bit address. It publishes the sample as `current_value`, which feeds the end-of-song detection back to the generator. It also pulses `count` to advance the address, and drives the speaker through an 8-bit PWM.

---
 rtl/pcm_sample_fetch.sv | 146 ++++++++++++++
 tb/tb_pcm_sample_fetch.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_sample_fetch.sv
// Sample-period PCM fetcher: once per SAMPLE_DIV cycles reads one 8-bit sample at the
// generator's address, publishes it as current_value, pulses count, and drives an 8-bit PWM.
module pcm_sample_fetch #(
    parameter int unsigned SAMPLE_DIV = 6250,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        play,
    input  logic [21:0] endereco,
    output logic [21:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic        count,
    output logic [7:0]  current_value,
    output logic        pwm_out,
    output logic        overrun,
    output logic        mem_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
    localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic [21:0] addr_q, addr_d;
    logic [7:0]  value_q, value_d;
    logic        overrun_q, overrun_d;
    logic        err_q, err_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [7:0]  pwm_level_q, pwm_level_d;
    logic        pwm_out_q, pwm_out_d;
    logic        tick;

    // Divider: held at 0 while stopped, so the first tick lands SAMPLE_DIV cycles after play rises.
    always_comb begin
        tick  = play && (div_q == DIV_LAST);
        div_d = div_q;
        if (!play) begin
            div_d = '0;
        end else if (tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + 16'd1;
        end
    end

    // Memory handshake: mem_rd is a request held with a stable mem_addr until the cycle mem_ack
    // is seen high (mem_data valid in that same cycle) or the timeout expires; acks while
    // mem_rd is low carry no meaning and are ignored.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        to_cnt_d  = to_cnt_q;
        value_d   = value_q;
        overrun_d = overrun_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    addr_d   = endereco;
                    to_cnt_d = '0;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    value_d = mem_data;
                    state_d = ST_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A tick that finds a fetch in flight is dropped and only flagged.
        if (tick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // PWM level reloads only at the period boundary so a duty change never splits a period.
    always_comb begin
        pwm_cnt_d   = pwm_cnt_q + 8'd1;
        pwm_level_d = pwm_level_q;
        if (pwm_cnt_q == 8'hFF) begin
            pwm_level_d = value_q;
        end
        pwm_out_d = (pwm_cnt_q < pwm_level_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            to_cnt_q    <= '0;
            addr_q      <= '0;
            value_q     <= '0;
            overrun_q   <= 1'b0;
            err_q       <= 1'b0;
            pwm_cnt_q   <= '0;
            pwm_level_q <= '0;
            pwm_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            to_cnt_q    <= to_cnt_d;
            addr_q      <= addr_d;
            value_q     <= value_d;
            overrun_q   <= overrun_d;
            err_q       <= err_d;
            pwm_cnt_q   <= pwm_cnt_d;
            pwm_level_q <= pwm_level_d;
            pwm_out_q   <= pwm_out_d;
        end
    end

    assign mem_addr      = addr_q;
    assign mem_rd        = (state_q == ST_REQ);
    assign count         = (state_q == ST_DONE);
    assign current_value = value_q;
    assign pwm_out       = pwm_out_q;
    assign overrun       = overrun_q;
    assign mem_err       = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_pcm_sample_fetch.sv
// Bench for pcm_sample_fetch: table of fetch vectors, memory responder feeding a value
// scoreboard, and hand-written PWM, reset-mid-fetch and overrun sequences.
module tb_pcm_sample_fetch;

    localparam int SAMPLE_DIV = 16;
    localparam int TIMEOUT    = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic [21:0] endereco;
    logic [21:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = 8'h00;
    logic        count;
    logic [7:0]  current_value;
    logic        pwm_out;
    logic        overrun;
    logic        mem_err;
    logic [1:0]  dbg_state;

    logic        o_play = 1'b0;
    logic [21:0] o_mem_addr;
    logic        o_mem_rd;
    logic        o_mem_ack = 1'b0;
    logic [7:0]  o_mem_data = 8'h00;
    logic        o_count;
    logic [7:0]  o_current_value;
    logic        o_pwm_out;
    logic        o_overrun;
    logic        o_mem_err;
    logic [1:0]  o_dbg_state;

    always #5 clk = ~clk;

    pcm_sample_fetch #(.SAMPLE_DIV(SAMPLE_DIV), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .reset(reset), .play(play), .endereco(endereco),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_data(mem_data),
        .count(count), .current_value(current_value), .pwm_out(pwm_out),
        .overrun(overrun), .mem_err(mem_err), .dbg_state(dbg_state)
    );

    // Second instance with a long timeout so a 20-cycle ack delay can overlap the next tick.
    pcm_sample_fetch #(.SAMPLE_DIV(SAMPLE_DIV), .TIMEOUT(32)) u_ovr (
        .clk(clk), .reset(reset), .play(o_play), .endereco(endereco),
        .mem_addr(o_mem_addr), .mem_rd(o_mem_rd), .mem_ack(o_mem_ack), .mem_data(o_mem_data),
        .count(o_count), .current_value(o_current_value), .pwm_out(o_pwm_out),
        .overrun(o_overrun), .mem_err(o_mem_err), .dbg_state(o_dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc++;

    // Memory responder: acks after ack_delay cycles of mem_rd, and optionally drives stray acks while idle.
    logic [7:0] exp_q[$];
    int         ack_delay = -1;
    logic [7:0] mem_value = 8'h00;
    bit         idle_ack  = 1'b0;
    int         rd_cycles = 0;

    always @(posedge clk) begin
        #2;
        if (mem_rd) begin
            if (rd_cycles == ack_delay) begin
                mem_ack  = 1'b1;
                mem_data = mem_value;
                exp_q.push_back(mem_value);
            end else begin
                mem_ack  = 1'b0;
                mem_data = 8'($urandom_range(0, 255));
            end
            rd_cycles++;
        end else begin
            rd_cycles = 0;
            mem_ack   = idle_ack;
            mem_data  = 8'hEE;
        end
    end

    // Scoreboard: each count pulse must publish the oldest acked sample.
    always @(posedge clk) begin
        #3;
        if (count) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_count: got count pulse (value 0x%0h) expected none", current_value);
            end else begin
                check("sb_value", 32'(current_value), 32'(exp_q.pop_front()));
            end
        end
    end

    typedef struct {
        logic [21:0] addr;
        logic [7:0]  data;
        int          delay;
        int          exp_len;
        logic        exp_cnt;
        logic [7:0]  exp_val;
        logic        exp_err;
    } vec_t;

    vec_t tbl[7];

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_fetch(input logic [7:0] d);
        int n;
        mem_value = d;
        ack_delay = 2;
        play      = 1'b1;
        n = 0;
        while (!count && n < 64) begin
            wait_cycles(1);
            n++;
        end
        check("fetch_count", 32'(count), 32'd1);
        play = 1'b0;
    endtask

    task automatic pwm_duty(input logic [7:0] d, input int exp_ones);
        int ones;
        do_fetch(d);
        wait_cycles(300);
        ones = 0;
        repeat (256) begin
            wait_cycles(1);
            ones += int'(pwm_out);
        end
        check("pwm_duty", 32'(ones), 32'(exp_ones));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, len, rise, prev, ones, rises, counts, rd_dly;
        logic prev_rd;
        logic [7:0] rdata;

        rdata  = 8'($urandom_range(1, 254));
        rd_dly = $urandom_range(0, 6);
        tbl[0] = '{22'h000100, 8'h0B, 2, 3, 1'b1, 8'h0B, 1'b0};
        tbl[1] = '{22'h3FFFFF, 8'hFF, 0, 1, 1'b1, 8'hFF, 1'b0};
        tbl[2] = '{22'h000000, 8'h00, 5, 6, 1'b1, 8'h00, 1'b0};
        tbl[3] = '{22'h2AAAAA, 8'h77, 7, 8, 1'b1, 8'h77, 1'b0};
        tbl[4] = '{22'h155555, 8'h55, -1, 8, 1'b0, 8'h77, 1'b1};
        tbl[5] = '{22'h012345, 8'h99, 1, 2, 1'b1, 8'h99, 1'b1};
        tbl[6] = '{22'h0ABCDE, rdata, rd_dly, rd_dly + 1, 1'b1, rdata, 1'b1};

        reset    = 1'b1;
        play     = 1'b0;
        endereco = '0;
        #3 reset = 1'b0;
        wait_cycles(2);
        check("rst_mem_rd", 32'(mem_rd), 0);
        check("rst_count", 32'(count), 0);
        check("rst_value", 32'(current_value), 0);
        check("rst_pwm", 32'(pwm_out), 0);
        check("rst_flags", {30'd0, overrun, mem_err}, 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_state", 32'(dbg_state), 0);
        wait_cycles(1);
        reset = 1'b1;
        wait_cycles(2);

        idle_ack  = 1'b1;
        endereco  = tbl[0].addr;
        mem_value = tbl[0].data;
        ack_delay = tbl[0].delay;
        play      = 1'b1;
        prev      = cyc;
        for (int i = 0; i < 7; i++) begin
            endereco  = tbl[i].addr;
            mem_value = tbl[i].data;
            ack_delay = tbl[i].delay;
            n = 0;
            while (!mem_rd && n < 64) begin
                wait_cycles(1);
                n++;
            end
            check("rd_rise", 32'(mem_rd), 1);
            if (!mem_rd) break;
            rise = cyc;
            check("tick_period", 32'(rise - prev), 32'(SAMPLE_DIV));
            check("addr_latch", 32'(mem_addr), 32'(tbl[i].addr));
            endereco = ~tbl[i].addr;
            len = 1;
            n = 0;
            while (n < 40) begin
                wait_cycles(1);
                n++;
                if (!mem_rd) break;
                len++;
            end
            check("rd_len", 32'(len), 32'(tbl[i].exp_len));
            check("count_pulse", 32'(count), 32'(tbl[i].exp_cnt));
            check("value", 32'(current_value), 32'(tbl[i].exp_val));
            check("mem_err", 32'(mem_err), 32'(tbl[i].exp_err));
            check("addr_hold", 32'(mem_addr), 32'(tbl[i].addr));
            wait_cycles(1);
            check("count_single", 32'(count), 0);
            prev = rise;
        end
        play = 1'b0;
        check("no_overrun", 32'(overrun), 0);

        pwm_duty(8'h40, 64);
        pwm_duty(8'hFF, 255);
        pwm_duty(8'h00, 0);

        // Reset one cycle into a fetch.
        ack_delay = 5;
        endereco  = 22'h00BEEF;
        play      = 1'b1;
        n = 0;
        while (!mem_rd && n < 64) begin
            wait_cycles(1);
            n++;
        end
        check("mid_rd_rise", 32'(mem_rd), 1);
        wait_cycles(1);
        check("mid_in_req", 32'(mem_rd), 1);
        reset = 1'b0;
        #1;
        check("mid_rst_rd", 32'(mem_rd), 0);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_value", 32'(current_value), 0);
        check("mid_rst_flags", {29'd0, pwm_out, overrun, mem_err}, 0);
        check("mid_rst_addr", 32'(mem_addr), 0);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        counts = 0;
        n = 0;
        while (!mem_rd && n < 64) begin
            wait_cycles(1);
            n++;
            counts += int'(count);
        end
        check("post_rst_latency", 32'(n), 32'(SAMPLE_DIV));
        check("post_rst_no_count", 32'(counts), 0);
        play = 1'b0;
        wait_cycles(20);

        // Overrun: ack 20 cycles into the request, second tick lands mid-fetch.
        o_play = 1'b1;
        n = 0;
        while (!o_mem_rd && n < 64) begin
            wait_cycles(1);
            n++;
        end
        check("ovr_rd_rise", 32'(o_mem_rd), 1);
        rises   = 1;
        counts  = 0;
        prev_rd = o_mem_rd;
        for (int k = 1; k <= 40; k++) begin
            wait_cycles(1);
            if (o_mem_rd && !prev_rd) rises++;
            prev_rd = o_mem_rd;
            counts += int'(o_count);
            if (k == 15) check("ovr_before_tick", 32'(o_overrun), 0);
            if (k == 16) check("ovr_at_tick", 32'(o_overrun), 1);
            if (k == 17) o_play = 1'b0;
            #1;
            o_mem_ack  = (k == 20);
            o_mem_data = (k == 20) ? 8'hA5 : 8'h3C;
        end
        check("ovr_fetches", 32'(rises), 1);
        check("ovr_counts", 32'(counts), 1);
        check("ovr_value", 32'(o_current_value), 32'h A5);
        check("ovr_no_err", 32'(o_mem_err), 0);
        check("ovr_sticky", 32'(o_overrun), 1);

        check("sb_drain", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
